// File: rtl/rf_wr_arb_if.sv
// Client-side and register-file-side signals of the write-port controller.
//   clr            : one-cycle pulse, restart the zero-fill sweep
//   req0/1         : client write requests (level, held until granted)
//   wa0/1, wd0/1   : client write address / data
//   gnt0/1         : combinational grants
//   ready          : combinational, high once the sweep has finished
//   rf_we/wa/wd    : registered register-file write port
interface rf_wr_arb_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16
);
    logic          clr;
    logic          req0;
    logic          req1;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          gnt0;
    logic          gnt1;
    logic          ready;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    // Client / testbench side
    modport master (
        output clr, req0, req1, wa0, wa1, wd0, wd1,
        input  gnt0, gnt1, ready, rf_we, rf_wa, rf_wd
    );

    // Controller side
    modport slave (
        input  clr, req0, req1, wa0, wa1, wd0, wd1,
        output gnt0, gnt1, ready, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_wr_arb.sv
// Write-port controller for a 2^AW x DW register file.
// Zero-fills every entry after reset or on clr, then shares the single write
// port between two clients with round-robin arbitration. Write controls to
// the register file are registered (one pipeline stage).
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : rf_wr_arb_if slave modport (client requests/grants, ready, rf write port)
module rf_wr_arb #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16
) (
    input  logic        clk,
    input  logic        rstn,
    rf_wr_arb_if.slave  bus
);

    localparam logic [AW-1:0] CNT_LAST = AW'((1 << AW) - 1);

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          gnt0_c, gnt1_c;

    // State and write-port registers; reset drops any pending write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state, grant and write-port selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;

        unique case (state_q)
            INIT: begin
                if (bus.clr) begin
                    // Restart the sweep; this cycle writes nothing.
                    cnt_d = '0;
                end else begin
                    we_d  = 1'b1;
                    wa_d  = cnt_q;
                    wd_d  = '0;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (bus.clr) begin
                    // clr beats any request; ptr is kept across the sweep.
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (bus.req0 && (!bus.req1 || !ptr_q)) begin
                    gnt0_c = 1'b1;
                    ptr_d  = 1'b1;
                    we_d   = 1'b1;
                    wa_d   = bus.wa0;
                    wd_d   = bus.wd0;
                end else if (bus.req1) begin
                    gnt1_c = 1'b1;
                    ptr_d  = 1'b0;
                    we_d   = 1'b1;
                    wa_d   = bus.wa1;
                    wd_d   = bus.wd1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign bus.gnt0  = gnt0_c;
    assign bus.gnt1  = gnt1_c;
    assign bus.ready = (state_q == ARB);
    assign bus.rf_we = we_q;
    assign bus.rf_wa = wa_q;
    assign bus.rf_wd = wd_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: directed scenarios plus randomized
// client traffic, checked every cycle against a behavioural model.
module tb_rf_wr_arb;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int NENT = 1 << AW;

    logic clk;
    logic rstn;

    rf_wr_arb_if #(.AW(AW), .DW(DW)) bus ();

    rf_wr_arb #(.AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Register file as seen through the DUT's write port.
    logic [DW-1:0] mem_dut [NENT];
    always @(posedge clk) begin
        if (bus.rf_we) mem_dut[bus.rf_wa] <= bus.rf_wd;
    end

    // Behavioural model.
    bit            m_sweep;   // zero-fill in progress
    int            m_idx;     // next entry the sweep writes
    int            m_pref;    // client favoured on contention
    bit            m_we;
    int            m_wa;
    int            m_wd;
    logic [DW-1:0] mem_m [NENT];
    bit            eg0, eg1;  // model grants of the last cycle
    bit            dut_g0, dut_g1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sweep = 1'b1;
        m_idx   = 0;
        m_pref  = 0;
        m_we    = 1'b0;
        m_wa    = 0;
        m_wd    = 0;
    endtask

    // One clock cycle: compare at negedge, advance model at the edge,
    // return 1 time unit after the edge so the caller can drive new inputs.
    task automatic cycle();
        bit n_sweep, n_we;
        int n_idx, n_pref, n_wa, n_wd;
        @(negedge clk);
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (rstn && !m_sweep && !bus.clr) begin
            if (bus.req0 && bus.req1) begin
                eg0 = (m_pref == 0);
                eg1 = (m_pref == 1);
            end else begin
                eg0 = bus.req0;
                eg1 = bus.req1;
            end
        end
        dut_g0 = bus.gnt0;
        dut_g1 = bus.gnt1;
        check("gnt0",  32'(bus.gnt0),  32'(eg0));
        check("gnt1",  32'(bus.gnt1),  32'(eg1));
        check("ready", 32'(bus.ready), 32'(rstn && !m_sweep));
        check("rf_we", 32'(bus.rf_we), 32'(m_we));
        check("rf_wa", 32'(bus.rf_wa), 32'(m_wa));
        check("rf_wd", 32'(bus.rf_wd), 32'(m_wd));

        n_sweep = m_sweep; n_idx = m_idx; n_pref = m_pref;
        n_we = 1'b0; n_wa = m_wa; n_wd = m_wd;
        if (rstn) begin
            if (m_sweep) begin
                if (bus.clr) begin
                    n_idx = 0;
                end else begin
                    n_we = 1'b1; n_wa = m_idx; n_wd = 0;
                    n_idx = m_idx + 1;
                    if (n_idx == NENT) begin
                        n_idx = 0;
                        n_sweep = 1'b0;
                    end
                end
            end else if (bus.clr) begin
                n_sweep = 1'b1;
                n_idx = 0;
            end else if (eg0) begin
                n_we = 1'b1; n_wa = int'(bus.wa0); n_wd = int'(bus.wd0); n_pref = 1;
            end else if (eg1) begin
                n_we = 1'b1; n_wa = int'(bus.wa1); n_wd = int'(bus.wd1); n_pref = 0;
            end
        end

        @(posedge clk);
        if (rstn && m_we) mem_m[m_wa] = DW'(m_wd);
        if (rstn) begin
            m_sweep = n_sweep; m_idx = n_idx; m_pref = n_pref;
            m_we = n_we; m_wa = n_wa; m_wd = n_wd;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.wa0 = '0; bus.wa1 = '0; bus.wd0 = '0; bus.wd1 = '0;
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) begin
            mem_dut[i] = 16'h5A5A;
            mem_m[i]   = 16'h5A5A;
        end
        idle_inputs();
        rstn = 1'b0;
        model_reset();

        // Reset state
        repeat (2) cycle();
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        check("rst_rf_wd", 32'(bus.rf_wd), 32'd0);

        // Sweep after release: 32 zero writes, then ready
        rstn = 1'b1;
        repeat (NENT) cycle();
        check("sweep_ready", 32'(bus.ready), 32'd1);
        check("sweep_last_wa", 32'(bus.rf_wa), 32'd31);
        check("sweep_last_we", 32'(bus.rf_we), 32'd1);
        cycle();
        check("sweep_done_we", 32'(bus.rf_we), 32'd0);

        // Single client
        bus.req1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 16'hBEEF;
        cycle();
        check("single_gnt1", 32'(dut_g1), 32'd1);
        check("single_we", 32'(bus.rf_we), 32'd1);
        check("single_wa", 32'(bus.rf_wa), 32'd7);
        check("single_wd", 32'(bus.rf_wd), 32'hBEEF);
        bus.req1 = 1'b0;

        // Contention: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            bus.req0 = 1'b1; bus.req1 = 1'b1;
            bus.wa0 = 5'(10 + k); bus.wa1 = 5'(20 + k);
            bus.wd0 = 16'(16'h1000 + k); bus.wd1 = 16'(16'h2000 + k);
            cycle();
            check("cont_gnt0", 32'(dut_g0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_wa", 32'(bus.rf_wa), (k % 2 == 0) ? 32'(10 + k) : 32'(20 + k));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // clr during ARB together with req0
        bus.clr = 1'b1; bus.req0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 16'h0333;
        cycle();
        check("clr_arb_gnt0", 32'(dut_g0), 32'd0);
        check("clr_arb_ready", 32'(bus.ready), 32'd0);
        bus.clr = 1'b0;
        repeat (NENT) cycle();
        cycle();
        check("clr_arb_first_gnt0", 32'(dut_g0), 32'd1);
        bus.req0 = 1'b0;

        // ptr (now favouring client 1) survives a clr sweep
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        repeat (NENT) cycle();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.wa0 = 5'd4; bus.wa1 = 5'd5; bus.wd0 = 16'h0444; bus.wd1 = 16'h0555;
        cycle();
        check("ptr_kept_gnt1", 32'(dut_g1), 32'd1);
        idle_inputs();

        // Async reset mid-sweep while rf_we=1
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        repeat (5) cycle();
        bus.req0 = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("arst_we", 32'(bus.rf_we), 32'd0);
        check("arst_ready", 32'(bus.ready), 32'd0);
        check("arst_gnt0", 32'(bus.gnt0), 32'd0);
        model_reset();
        bus.req0 = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;

        // clr mid-sweep at cnt=10
        repeat (10) cycle();
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        cycle();
        check("msclr_wa", 32'(bus.rf_wa), 32'd0);
        check("msclr_we", 32'(bus.rf_we), 32'd1);
        repeat (30) cycle();
        check("msclr_ready_lo", 32'(bus.ready), 32'd0);
        cycle();
        check("msclr_ready_hi", 32'(bus.ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (!bus.req0 || eg0) begin
                bus.req0 = ($urandom_range(0, 9) < 6);
                bus.wa0  = 5'($urandom_range(0, 31));
                bus.wd0  = 16'($urandom);
            end
            if (!bus.req1 || eg1) begin
                bus.req1 = ($urandom_range(0, 9) < 6);
                bus.wa1  = 5'($urandom_range(0, 31));
                bus.wd1  = 16'($urandom);
            end
            bus.clr = ($urandom_range(0, 79) == 0);
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        // Register file contents
        for (int i = 0; i < NENT; i++) begin
            check("mem", 32'(mem_dut[i]), 32'(mem_m[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
